seq_det_multi: RTL

Parametrised, runtime-programmable serial sequence detector. It watches the one-bit stream `x` for up to `N_PAT` bit patterns, each up to `MAX_LEN` bits long. For every pattern it produces a registered Moore-style hit flag, a saturating hit counter and a priority-encoded match code. The block supersedes the fixed hard-coded pattern FSMs used in the lab datapath, and adds overlap/non-overlap modes and stall handling via `x_valid`.

---
 rtl/seq_det_pkg.sv | 24 ++
 rtl/seq_det_slot.sv | 82 ++++++++
 rtl/seq_det_multi.sv | 116 +++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared width helpers and counter constants for the serial sequence detector.
package seq_det_pkg;

    // Bits needed to hold a pattern length or history fill count (0..max_len).
    function automatic int LEN_W(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Bits needed to address a pattern slot; never narrower than one bit.
    function automatic int IDX_W(input int n_pat);
        return (n_pat > 1) ? $clog2(n_pat) : 1;
    endfunction

    // Bits needed for the match code (0 = no hit, 1..n_pat = slot index + 1).
    function automatic int CODE_W(input int n_pat);
        return $clog2(n_pat + 1);
    endfunction

    // All-ones saturation value of a hit counter of the given width (up to 31 bits).
    function automatic logic [31:0] cnt_sat(input int cnt_w);
        return (32'h1 << cnt_w) - 32'h1;
    endfunction

endpackage

// File: rtl/seq_det_slot.sv
// One pattern slot: stored pattern/length, masked comparator, hit flag and hit counter.
module seq_det_slot
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_sel_i,
    input  logic                        cfg_we_i,
    input  logic [MAX_LEN-1:0]          cfg_pat_i,
    input  logic [LEN_W(MAX_LEN)-1:0]   cfg_len_i,
    input  logic                        acc_i,
    input  logic [MAX_LEN-1:0]          hist_n_i,
    input  logic [LEN_W(MAX_LEN)-1:0]   fill_n_i,
    input  logic                        cnt_clr_i,
    output logic                        match_o,
    output logic                        hit_o,
    output logic [CNT_W-1:0]            cnt_o
);

    localparam int             LW      = LEN_W(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat(CNT_W));

    logic [MAX_LEN-1:0] pat_q;
    logic [LW-1:0]      len_q;
    logic               hit_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               bits_eq;
    logic               len_ok;

    // Slot configuration registers; a zero or oversized length leaves the slot disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= '0;
            len_q <= '0;
        end else if (cfg_sel_i) begin
            pat_q <= cfg_pat_i;
            len_q <= cfg_len_i;
        end
    end

    // Compare only the lowest len bits of the candidate history against the pattern.
    always_comb begin
        bits_eq = 1'b1;
        for (int j = 0; j < MAX_LEN; j++) begin
            if ((j < int'(len_q)) && (hist_n_i[j] != pat_q[j])) begin
                bits_eq = 1'b0;
            end
        end
    end

    assign len_ok  = (len_q != '0) && (len_q <= LW'(MAX_LEN));
    assign match_o = len_ok && (fill_n_i >= len_q) && bits_eq;

    // Moore hit flag: reloaded on every accepted bit, dropped by any config write.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q <= 1'b0;
        end else if (cfg_we_i) begin
            hit_q <= 1'b0;
        end else if (acc_i) begin
            hit_q <= match_o;
        end
    end

    // Saturating hit counter; a clear request beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (cnt_clr_i) begin
            cnt_q <= '0;
        end else if (acc_i && match_o && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign hit_o = hit_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_det_multi.sv
// Runtime-programmable multi-pattern serial sequence detector: shared bit history,
// fill tracking with overlap/non-overlap restart, and a priority-encoded match code.
module seq_det_multi
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int N_PAT   = 2,
    parameter int CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        x_valid_i,
    input  logic                        x_i,
    input  logic                        overlap_i,
    input  logic                        cfg_we_i,
    input  logic [IDX_W(N_PAT)-1:0]     cfg_idx_i,
    input  logic [MAX_LEN-1:0]          cfg_pat_i,
    input  logic [LEN_W(MAX_LEN)-1:0]   cfg_len_i,
    input  logic                        cnt_clr_i,
    output logic [N_PAT-1:0]            hit_o,
    output logic [CODE_W(N_PAT)-1:0]    y_o,
    output logic [N_PAT*CNT_W-1:0]      hit_cnt_o,
    output logic [MAX_LEN-1:0]          hist_o,
    output logic [LEN_W(MAX_LEN)-1:0]   fill_o
);

    localparam int LW = LEN_W(MAX_LEN);
    localparam int CW = CODE_W(N_PAT);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LW-1:0]      fill_q, fill_n, fill_d;
    logic [CW-1:0]      y_q, y_d;
    logic [N_PAT-1:0]   match;
    logic [N_PAT-1:0]   cfg_sel;
    logic               acc;
    logic               any_match;

    // A config write takes the cycle; any bit offered alongside it is dropped.
    assign acc       = x_valid_i && !cfg_we_i;
    assign hist_d    = {hist_q[MAX_LEN-2:0], x_i};
    assign fill_n    = (fill_q >= LW'(MAX_LEN)) ? LW'(MAX_LEN) : (fill_q + LW'(1));
    assign any_match = |match;
    assign fill_d    = (any_match && !overlap_i) ? '0 : fill_n;

    genvar gi;
    generate
        for (gi = 0; gi < N_PAT; gi++) begin : g_slot
            assign cfg_sel[gi] = cfg_we_i && (int'(cfg_idx_i) == gi);

            seq_det_slot #(
                .MAX_LEN (MAX_LEN),
                .CNT_W   (CNT_W)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .cfg_sel_i (cfg_sel[gi]),
                .cfg_we_i  (cfg_we_i),
                .cfg_pat_i (cfg_pat_i),
                .cfg_len_i (cfg_len_i),
                .acc_i     (acc),
                .hist_n_i  (hist_d),
                .fill_n_i  (fill_n),
                .cnt_clr_i (cnt_clr_i),
                .match_o   (match[gi]),
                .hit_o     (hit_o[gi]),
                .cnt_o     (hit_cnt_o[gi*CNT_W +: CNT_W])
            );
        end
    endgenerate

    // Lowest-numbered matching slot wins; code is its index plus one.
    always_comb begin
        y_d = '0;
        for (int i = N_PAT - 1; i >= 0; i--) begin
            if (match[i]) begin
                y_d = CW'(i + 1);
            end
        end
    end

    // Bit history keeps shifting on every accepted bit, regardless of hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= '0;
        end else if (acc) begin
            hist_q <= hist_d;
        end
    end

    // Fill count: restarted by config writes and, in non-overlap mode, by any hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_q <= '0;
        end else if (cfg_we_i) begin
            fill_q <= '0;
        end else if (acc) begin
            fill_q <= fill_d;
        end
    end

    // Registered match code, held between accepted bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= '0;
        end else if (cfg_we_i) begin
            y_q <= '0;
        end else if (acc) begin
            y_q <= y_d;
        end
    end

    assign y_o    = y_q;
    assign hist_o = hist_q;
    assign fill_o = fill_q;

endmodule
